// File: rtl/microcode_step_sequencer_pkg.sv
// microcode_step_sequencer_pkg: shared step, state and unit encodings for the control unit
package microcode_step_sequencer_pkg;

    typedef enum logic [3:0] {
        T1 = 4'b0001,
        T2 = 4'b0010,
        T3 = 4'b0100,
        T4 = 4'b1000
    } step_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam int MCYCLE_MAX = 7;

    // Decoder index to microcode unit mapping
    typedef enum logic [2:0] {
        UNIT_LOAD  = 3'd0,
        UNIT_ALU   = 3'd1,
        UNIT_JUMP  = 3'd2,
        UNIT_STACK = 3'd3,
        UNIT_IO    = 3'd4,
        UNIT_BIT   = 3'd5,
        UNIT_MISC  = 3'd6,
        UNIT_HALT  = 3'd7
    } unit_e;

endpackage

// File: rtl/microcode_step_sequencer_if.sv
// microcode_step_sequencer_if: decoder/microcode-unit side signals of the step sequencer
interface microcode_step_sequencer_if #(
    parameter int NUM_UNITS = 8,
    parameter int UNIT_W    = 3
);
    logic                 ce;
    logic                 mem_wait;
    logic [UNIT_W-1:0]    unit_sel;
    logic                 ir_fetch;
    logic                 halt_req;
    logic                 int_pending;
    logic [3:0]           cycle_step;
    logic [2:0]           m_cycle;
    logic [NUM_UNITS-1:0] unit_active;
    logic                 ir_load;
    logic                 halted;
    logic                 overrun;

    modport master (
        input  ce, mem_wait, unit_sel, ir_fetch, halt_req, int_pending,
        output cycle_step, m_cycle, unit_active, ir_load, halted, overrun
    );

    modport slave (
        output ce, mem_wait, unit_sel, ir_fetch, halt_req, int_pending,
        input  cycle_step, m_cycle, unit_active, ir_load, halted, overrun
    );
endinterface

// File: rtl/microcode_step_sequencer_tstate_ring.sv
// tstate_ring: one-hot T1..T4 ring with CE gating, T2 wait hold and a leaving-T4 strobe
module tstate_ring
    import microcode_step_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       mem_wait,
    output logic [3:0] step,
    output logic       leave_t4
);
    logic [3:0] step_nx;

    // Any illegal pattern falls back to T1 so the ring self-recovers
    always_comb begin
        step_nx  = (!ce || (step == T2 && mem_wait)) ? step :
                   step == T1 ? T2 :
                   step == T2 ? T3 :
                   step == T3 ? T4 : T1;
        leave_t4 = ce && step == T4;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) step <= T1;
        else     step <= step_nx;
endmodule

// File: rtl/microcode_step_sequencer.sv
// microcode_step_sequencer: T-state/M-cycle master sequencer selecting the active microcode unit
module microcode_step_sequencer
    import microcode_step_sequencer_pkg::*;
#(
    parameter int NUM_UNITS = 8,
    parameter int UNIT_W    = 3
) (
    input logic clk,
    input logic rst,
    microcode_step_sequencer_if.master bus
);
    localparam logic [NUM_UNITS-1:0] ONE = 1;

    logic [3:0]           step;
    logic                 end_m;
    logic                 leave_t1;
    logic                 unit_ok;
    logic                 halt_go;
    logic                 load_go;
    logic [NUM_UNITS-1:0] unit_hot;
    state_e               state;
    logic [2:0]           m;
    logic [NUM_UNITS-1:0] unit;
    logic                 ir_load;
    logic                 halted;
    logic                 overrun;

    tstate_ring u_ring (
        .clk      (clk),
        .rst      (rst),
        .ce       (bus.ce),
        .mem_wait (bus.mem_wait),
        .step     (step),
        .leave_t4 (end_m)
    );

    // A pending interrupt turns a HALT request into an ordinary fetch
    always_comb begin
        leave_t1 = bus.ce && step == T1;
        unit_ok  = int'(bus.unit_sel) < NUM_UNITS;
        unit_hot = unit_ok ? ONE << bus.unit_sel : '0;
        halt_go  = bus.halt_req && !bus.int_pending;
        load_go  = bus.halt_req || bus.ir_fetch;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= FETCH;
            m       <= '0;
            unit    <= '0;
            ir_load <= 1'b0;
            halted  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            ir_load <= 1'b0;
            if (leave_t1 && state == EXEC && m == '0) begin
                unit <= unit_hot;
                if (!unit_ok) overrun <= 1'b1;
            end
            if (end_m)
                case (state)
                    FETCH: begin
                        ir_load <= 1'b1;
                        state   <= EXEC;
                        m       <= '0;
                        unit    <= '0;
                    end
                    EXEC: begin
                        if (halt_go) begin
                            state  <= HALT;
                            halted <= 1'b1;
                            unit   <= '0;
                            m      <= '0;
                        end else if (load_go) begin
                            ir_load <= 1'b1;
                            unit    <= '0;
                            m       <= '0;
                        end else if (m == 3'(MCYCLE_MAX)) overrun <= 1'b1;
                        else m <= m + 3'd1;
                    end
                    HALT: begin
                        m <= '0;
                        if (bus.int_pending) begin
                            state  <= FETCH;
                            halted <= 1'b0;
                        end
                    end
                    default: state <= FETCH;
                endcase
        end

    assign bus.cycle_step  = step;
    assign bus.m_cycle     = m;
    assign bus.unit_active = unit;
    assign bus.ir_load     = ir_load;
    assign bus.halted      = halted;
    assign bus.overrun     = overrun;
endmodule

// File: tb/tb_microcode_step_sequencer.sv
// tb_microcode_step_sequencer: directed and random checks against a T-index/mode reference model
module tb_microcode_step_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: T index 0..3, mode 0=fetch 1=exec 2=halt
    int         mt, mmode, mm;
    logic       mir, mhalt, mov;
    logic [7:0] munit;

    microcode_step_sequencer_if bus ();

    microcode_step_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mt = 0; mmode = 0; mm = 0; mir = 0; mhalt = 0; mov = 0; munit = '0;
    endtask

    task automatic model_clock();
        mir = 0;
        if (bus.ce) begin
            if (mt == 0 && mmode == 1 && mm == 0) munit = 8'd1 << bus.unit_sel;
            if (mt == 3) begin
                if (mmode == 0) begin
                    mir = 1; mmode = 1; mm = 0; munit = '0;
                end else if (mmode == 1) begin
                    if (bus.halt_req && !bus.int_pending) begin
                        mmode = 2; mhalt = 1; mm = 0; munit = '0;
                    end else if (bus.halt_req || bus.ir_fetch) begin
                        mir = 1; mm = 0; munit = '0;
                    end else if (mm >= 7) mov = 1;
                    else mm++;
                end else if (bus.int_pending) begin
                    mmode = 0; mhalt = 0;
                end
            end
            if (!(mt == 1 && bus.mem_wait)) mt = (mt + 1) % 4;
        end
    endtask

    task automatic cmp_all();
        chk("cycle_step", bus.cycle_step, 32'd1 << mt);
        chk("m_cycle", bus.m_cycle, mm);
        chk("unit_active", bus.unit_active, munit);
        chk("ir_load", bus.ir_load, mir);
        chk("halted", bus.halted, mhalt);
        chk("overrun", bus.overrun, mov);
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_step", bus.cycle_step, 4'b0001);
        chk("async_rst_overrun", bus.overrun, 1'b0);
        cmp_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.ce = 1'b1; bus.mem_wait = 1'b0; bus.unit_sel = 3'd2;
        bus.ir_fetch = 1'b0; bus.halt_req = 1'b0; bus.int_pending = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_step", bus.cycle_step, 4'b0001);
        cmp_all();
        rst = 1'b0;
        // First fetch, then unit latch from decoder index 2
        ticks(3);
        chk("lit_t4", bus.cycle_step, 4'b1000);
        tick();
        chk("lit_ir_load", bus.ir_load, 1'b1);
        chk("lit_unit_zero_t1", bus.unit_active, 8'h00);
        tick();
        chk("lit_unit_active", bus.unit_active, 8'b0000_0100);
        chk("lit_ir_load_drop", bus.ir_load, 1'b0);
        // Wait stall at T2, then CE freeze
        bus.mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_wait_hold", bus.cycle_step, 4'b0010);
        end
        bus.mem_wait = 1'b0;
        tick();
        chk("lit_wait_release", bus.cycle_step, 4'b0100);
        bus.ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lit_ce_freeze", bus.cycle_step, 4'b0100);
        end
        bus.ce = 1'b1;
        // Multi-cycle instruction fetching in M2
        ticks(2);
        chk("lit_m1", bus.m_cycle, 3'd1);
        ticks(4);
        chk("lit_m2", bus.m_cycle, 3'd2);
        ticks(3);
        bus.ir_fetch = 1'b1;
        tick();
        bus.ir_fetch = 1'b0;
        chk("lit_m_wrap", bus.m_cycle, 3'd0);
        chk("lit_fetch_load", bus.ir_load, 1'b1);
        // Runaway to saturation, then reset mid-T3
        ticks(32);
        chk("lit_m_sat", bus.m_cycle, 3'd7);
        chk("lit_overrun", bus.overrun, 1'b1);
        ticks(2);
        chk("lit_at_t3", bus.cycle_step, 4'b0100);
        async_reset();
        // HALT entry and interrupt wake-up
        ticks(7);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        chk("lit_halted", bus.halted, 1'b1);
        chk("lit_halt_unit", bus.unit_active, 8'h00);
        ticks(7);
        bus.int_pending = 1'b1;
        tick();
        bus.int_pending = 1'b0;
        chk("lit_wake", bus.halted, 1'b0);
        ticks(3);
        chk("lit_wake_no_load", bus.ir_load, 1'b0);
        tick();
        chk("lit_wake_load", bus.ir_load, 1'b1);
        // HALT request with interrupt pending behaves as a fetch
        ticks(3);
        bus.halt_req = 1'b1; bus.int_pending = 1'b1;
        tick();
        bus.halt_req = 1'b0; bus.int_pending = 1'b0;
        chk("lit_simul_load", bus.ir_load, 1'b1);
        chk("lit_simul_halted", bus.halted, 1'b0);
        // Random phase
        for (int i = 0; i < 3000; i++) begin
            bus.ce          = $urandom_range(0, 9) < 8;
            bus.mem_wait    = $urandom_range(0, 3) == 0;
            bus.unit_sel    = 3'($urandom_range(0, 7));
            bus.ir_fetch    = $urandom_range(0, 9) < 3;
            bus.halt_req    = $urandom_range(0, 19) == 0;
            bus.int_pending = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 499) == 0) async_reset();
            else tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
